// File: rtl/sfifo_pkg.sv
// Shared constants for sfifo and the blocks that sit next to it.
package sfifo_pkg;

   localparam int unsigned SFIFO_DATA_W       = 8;
   localparam int unsigned SFIFO_RD_LAT       = 2;
   localparam int unsigned SFIFO_EMPTY_THRESH = 2;
   localparam int unsigned SFIFO_FULL_THRESH  = 62;

   // Number of reads still travelling through the read-latency pipe.
   function automatic logic [1:0] rd_pipe_popcount(input logic [SFIFO_RD_LAT-1:0] pipe);
      logic [1:0] n;
      n = '0;
      for (int unsigned i = 0; i < SFIFO_RD_LAT; i++) begin
         n = n + 2'(pipe[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/sfifo_rd_buf.sv
// Small circular buffer with an occupancy count; head is the oldest entry.
module sfifo_rd_buf #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    pop,
   output logic [$clog2(DEPTH):0]  count,
   output logic [DATA_W-1:0]       head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count_d;
   logic              pop_ok;

   // A pop on an empty buffer is ignored so the pointers can never skew.
   assign pop_ok = pop & (count != '0);
   assign head   = mem[rd_ptr];

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count;
      unique case ({push, pop_ok})
         2'b10:   count_d = count + (AW+1)'(1);
         2'b01:   count_d = count - (AW+1)'(1);
         default: count_d = count;
      endcase
   end

   // Storage, pointers and count; storage is cleared so head reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i[AW-1:0]] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_d;
      end
   end

endmodule

// File: rtl/sfifo_rd_stream.sv
// Read-side adapter for sfifo: issues reads, captures dout at the fixed read
// latency and presents the bytes as a valid/ready stream.
module sfifo_rd_stream
   import sfifo_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = SFIFO_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic              fifo_underflow,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_r_en,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [1:0]        inflight,
   output logic              err
);

   localparam int unsigned CW        = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_LIM = DEPTH[CW:0];

   // Power-of-two depth keeps pointer wrap free; at least 4 gives full-rate bursts.
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("sfifo_rd_stream: DEPTH must be a power of two and at least 4");
   end

   // The empty threshold must cover every read that sfifo has not yet reflected.
   if (SFIFO_RD_LAT > SFIFO_EMPTY_THRESH) begin : g_lat_check
      $error("sfifo_rd_stream: read latency exceeds the sfifo empty threshold");
   end

   logic [SFIFO_RD_LAT-1:0] rd_pipe;
   logic [CW-1:0]           count;
   logic [CW:0]             reserved;
   logic                    capture;
   logic                    pop;

   assign inflight = rd_pipe_popcount(rd_pipe);

   // Space already committed: bytes held plus reads whose data is still on the way.
   assign reserved = {1'b0, count} + {{(CW-1){1'b0}}, inflight};

   // Issue only when every outstanding read is guaranteed a buffer slot; held low in reset.
   assign fifo_r_en = rst & en & ~fifo_empty & (reserved < DEPTH_LIM);

   assign capture = rd_pipe[SFIFO_RD_LAT-1];
   assign m_valid = (count != '0);
   assign pop     = m_valid & m_ready;

   // Shift issued reads along so capture lines up with dout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe <= {rd_pipe[SFIFO_RD_LAT-2:0], fifo_r_en};
      end
   end

   // Sticky record of any sfifo underflow; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (fifo_underflow) begin
         err <= 1'b1;
      end
   end

   sfifo_rd_buf #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (capture),
      .push_data (fifo_dout),
      .pop       (pop),
      .count     (count),
      .head      (m_data)
   );

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench for sfifo_rd_stream with a behavioural sfifo on its read side.
module tb_sfifo_rd_stream;
   import sfifo_pkg::*;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned DW         = SFIFO_DATA_W;
   localparam int unsigned FIFO_SLOTS = SFIFO_FULL_THRESH + 2;

   logic          clk;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic          fifo_underflow;
   logic [DW-1:0] fifo_dout;
   logic          fifo_r_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [1:0]    inflight;
   logic          err;

   // sfifo model state
   logic          w_en;
   logic [DW-1:0] w_data;
   logic          force_uf;
   logic [DW-1:0] mem [FIFO_SLOTS];
   logic [5:0]    wp;
   logic [5:0]    rp;
   logic [6:0]    occ;
   logic [6:0]    occ_n;
   logic          r_en_q;
   logic          uf_q;

   int checks;
   int errors;
   int cyc;
   int issued;
   int pops;
   int first_iss;
   int last_iss;
   int first_val;
   int first_pop;
   int last_pop;
   logic [DW-1:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sfifo_rd_stream #(
      .DEPTH  (DEPTH),
      .DATA_W (DW)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_dout      (fifo_dout),
      .fifo_r_en      (fifo_r_en),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_ready        (m_ready),
      .inflight       (inflight),
      .err            (err)
   );

   // sfifo: r_en registered, dout two cycles after r_en is sampled, empty registered
   // from occupancy with threshold 2.
   always_comb begin
      occ_n = occ;
      if (w_en) occ_n = occ_n + 7'd1;
      if (fifo_r_en && occ != 7'd0) occ_n = occ_n - 7'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp         <= '0;
         rp         <= '0;
         occ        <= '0;
         r_en_q     <= 1'b0;
         fifo_dout  <= '0;
         fifo_empty <= 1'b1;
         uf_q       <= 1'b0;
      end else begin
         r_en_q <= fifo_r_en;
         if (r_en_q) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 6'd1;
         end
         if (w_en) wp <= wp + 6'd1;
         occ        <= occ_n;
         fifo_empty <= (32'(occ_n) <= SFIFO_EMPTY_THRESH);
         uf_q       <= fifo_r_en && (occ == 7'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_en) mem[wp] <= w_data;
   end

   assign fifo_underflow = uf_q | force_uf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_trk();
      issued    = 0;
      pops      = 0;
      first_iss = -1;
      last_iss  = -1;
      first_val = -1;
      first_pop = -1;
      last_pop  = -1;
   endtask

   // One clock: observe at the falling edge, return 1 time unit after the rising edge.
   task automatic tick();
      logic [DW-1:0] exp_b;
      @(negedge clk);
      if (fifo_r_en) begin
         issued++;
         if (first_iss < 0) first_iss = cyc;
         last_iss = cyc;
      end
      if (m_valid && first_val < 0) first_val = cyc;
      if (m_valid && m_ready) begin
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pop_extra: observed byte %0h expected none", m_data);
         end else begin
            exp_b = exp_q.pop_front();
            check("m_data_order", 32'(m_data), 32'(exp_b));
         end
      end
      checks++;
      assert (u_dut.count <= DEPTH) else begin
         errors++;
         $error("FAIL count_bound: observed %0d expected <= %0d", u_dut.count, DEPTH);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [DW-1:0] b);
      w_en   = 1'b1;
      w_data = b;
      exp_q.push_back(b);
      tick();
      w_en   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_r_en"}, 32'(fifo_r_en), 32'd0);
      check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_m_data"}, 32'(m_data), 32'd0);
      check({tag, "_inflight"}, 32'(inflight), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      rst      = 1'b0;
      en       = 1'b0;
      m_ready  = 1'b0;
      w_en     = 1'b0;
      w_data   = '0;
      force_uf = 1'b0;
      reset_trk();

      // Power-on reset
      #2;
      check_reset_outputs("por");
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Ten bytes, full-rate drain; last two stay in sfifo
      for (int i = 0; i < 10; i++) write_byte(8'(i));
      tick();
      tick();
      reset_trk();
      en      = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("burst_issued", 32'(issued), 32'd8);
      check("burst_consecutive", 32'(last_iss - first_iss + 1), 32'd8);
      check("burst_latency", 32'(first_val - first_iss), 32'd3);
      check("burst_pops", 32'(pops), 32'd8);
      check("burst_held", 32'(exp_q.size()), 32'd2);
      check("burst_idle_valid", 32'(m_valid), 32'd0);

      // Backpressure: buffer fills to DEPTH and issue stops
      m_ready = 1'b0;
      reset_trk();
      for (int i = 0; i < 20; i++) write_byte(8'(8'h10 + i));
      for (int i = 0; i < 10; i++) tick();
      check("bp_issued", 32'(issued), 32'd4);
      check("bp_count", 32'(u_dut.count), 32'd4);
      check("bp_inflight", 32'(inflight), 32'd0);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_head", 32'(m_data), 32'h08);
      for (int i = 0; i < 5; i++) tick();
      check("bp_no_more_issue", 32'(issued), 32'd4);
      m_ready = 1'b1;
      reset_trk();
      for (int i = 0; i < 30; i++) tick();
      check("resume_pops", 32'(pops), 32'd20);
      check("resume_gapless", 32'(last_pop - first_pop + 1), 32'd20);
      check("resume_held", 32'(exp_q.size()), 32'd2);

      // sfifo holding two bytes: no read, no error
      reset_trk();
      for (int i = 0; i < 10; i++) tick();
      check("low_occ_issued", 32'(issued), 32'd0);
      check("low_occ_err", 32'(err), 32'd0);
      check("low_occ_inflight", 32'(inflight), 32'd0);

      // Drop en right after two reads are issued
      en = 1'b0;
      for (int i = 0; i < 6; i++) write_byte(8'(8'h30 + i));
      tick();
      tick();
      reset_trk();
      en = 1'b1;
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("en_drop_issued", 32'(issued), 32'd2);
      check("en_drop_pops", 32'(pops), 32'd2);
      check("en_drop_left", 32'(exp_q.size()), 32'd6);

      // Single-cycle underflow pulse makes err sticky; data order unaffected
      force_uf = 1'b1;
      tick();
      force_uf = 1'b0;
      check("uf_err_set", 32'(err), 32'd1);
      reset_trk();
      en = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("uf_err_sticky", 32'(err), 32'd1);
      check("uf_pops", 32'(pops), 32'd4);
      check("uf_left", 32'(exp_q.size()), 32'd2);

      // Reset mid-burst with two reads in flight and m_ready low
      en      = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) write_byte(8'(8'h40 + i));
      tick();
      tick();
      en = 1'b1;
      tick();
      tick();
      check("mid_inflight", 32'(inflight), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      exp_q.delete();
      en = 1'b0;
      tick();
      check_reset_outputs("mid_rst_held");
      rst = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) write_byte(8'(8'hA0 + i));
      reset_trk();
      en      = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("post_rst_pops", 32'(pops), 32'd3);
      check("post_rst_left", 32'(exp_q.size()), 32'd2);
      check("post_rst_err", 32'(err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
